// File: rtl/par_conv_pkg.sv
// ============================================================================
// Module  : par_conv_pkg
// Brief   : Shared types and constants for the par_conv_stream 3-tap filter.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package par_conv_pkg;

    localparam int ACC_EXTRA = 6;
    localparam int TAP_W     = 4;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/par_conv_lane.sv
// ============================================================================
// Module  : par_conv_lane
// Brief   : One-pixel 3-tap weighted sum, normalising shift and wrap/clamp.
//           Clamping is enabled by defining PAR_CONV_SATURATE_EN.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module par_conv_lane
    import par_conv_pkg::*;
#(
    parameter int               PIXELWIDTH = 8,
    parameter logic [TAP_W-1:0] W0         = 4'd1,
    parameter logic [TAP_W-1:0] W1         = 4'd2,
    parameter logic [TAP_W-1:0] W2         = 4'd1,
    parameter int               SHIFT      = 2
) (
    input  logic [PIXELWIDTH-1:0] i_left,
    input  logic [PIXELWIDTH-1:0] i_centre,
    input  logic [PIXELWIDTH-1:0] i_right,
    output logic [PIXELWIDTH-1:0] o_pix
);

    localparam int ACC_W = PIXELWIDTH + ACC_EXTRA;

    logic [ACC_W-1:0] w_acc;

    assign w_acc = ACC_W'(W0) * ACC_W'(i_left)
                 + ACC_W'(W1) * ACC_W'(i_centre)
                 + ACC_W'(W2) * ACC_W'(i_right);

`ifdef PAR_CONV_SATURATE_EN
    localparam logic [ACC_W-1:0] c_PIX_MAX = ACC_W'((1 << PIXELWIDTH) - 1);

    logic [ACC_W-1:0] w_norm;

    assign w_norm = w_acc >> SHIFT;
    assign o_pix  = (w_norm > c_PIX_MAX) ? '1 : w_norm[PIXELWIDTH-1:0];
`else
    assign o_pix  = PIXELWIDTH'(w_acc >> SHIFT);
`endif

endmodule

`default_nettype wire

// File: rtl/par_conv_stream.sv
// ============================================================================
// Module  : par_conv_stream
// Brief   : Streaming multi-lane horizontal 3-tap filter with edge replication.
//           Define PAR_CONV_SATURATE_EN to clamp instead of wrap on overflow.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module par_conv_stream
    import par_conv_pkg::*;
#(
    parameter int               BITS     = 3,
    parameter int               LANES    = 2,
    parameter int               LINE_LEN = 8,
    parameter logic [TAP_W-1:0] W0       = 4'd1,
    parameter logic [TAP_W-1:0] W1       = 4'd2,
    parameter logic [TAP_W-1:0] W2       = 4'd1,
    parameter int               SHIFT    = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [LANES*(2**BITS)-1:0]        in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic [LANES*(2**BITS)-1:0]        out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              out_last
);

    localparam int PW     = 2 ** BITS;
    localparam int DW     = LANES * PW;
    localparam int NBEATS = LINE_LEN / LANES;
    localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CNT_W-1:0] c_LAST_BEAT = CNT_W'(NBEATS - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_beat_cnt;
    logic [DW-1:0]    r_cur;
    logic [PW-1:0]    r_left;
    logic [DW-1:0]    r_out_data;
    logic             r_out_valid;
    logic             r_out_last;

    logic             w_slot_free;
    logic             w_in_fire;
    logic             w_last_beat;
    logic [PW-1:0]    w_right_in;
    logic [DW-1:0]    w_filt;

    assign w_slot_free = !r_out_valid || out_ready;
    assign in_ready    = rst_n && w_slot_free && (r_state != ST_FLUSH);
    assign w_in_fire   = in_valid && in_ready;
    assign w_last_beat = (r_beat_cnt == c_LAST_BEAT);

    // Right neighbour of the top lane: next beat's first pixel, or replicated at line end.
    assign w_right_in  = (r_state == ST_FLUSH) ? r_cur[(LANES-1)*PW +: PW] : in_data[PW-1:0];

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            logic [PW-1:0] w_l;
            logic [PW-1:0] w_r;

            if (i == 0) begin : g_left_edge
                assign w_l = r_left;
            end else begin : g_left_inner
                assign w_l = r_cur[(i-1)*PW +: PW];
            end

            if (i == LANES - 1) begin : g_right_edge
                assign w_r = w_right_in;
            end else begin : g_right_inner
                assign w_r = r_cur[(i+1)*PW +: PW];
            end

            par_conv_lane #(
                .PIXELWIDTH (PW),
                .W0         (W0),
                .W1         (W1),
                .W2         (W2),
                .SHIFT      (SHIFT)
            ) u_lane (
                .i_left   (w_l),
                .i_centre (r_cur[i*PW +: PW]),
                .i_right  (w_r),
                .o_pix    (w_filt[i*PW +: PW])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_FILL;
            r_beat_cnt  <= '0;
            r_cur       <= '0;
            r_left      <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (w_in_fire) begin
                r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + CNT_W'(1);
            end

            case (r_state)
                ST_FILL: begin
                    if (w_in_fire) begin
                        r_cur   <= in_data;
                        r_left  <= in_data[PW-1:0];
                        r_state <= w_last_beat ? ST_FLUSH : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_in_fire) begin
                        r_out_data  <= w_filt;
                        r_out_valid <= 1'b1;
                        r_out_last  <= 1'b0;
                        r_left      <= r_cur[(LANES-1)*PW +: PW];
                        r_cur       <= in_data;
                        r_state     <= w_last_beat ? ST_FLUSH : ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    if (w_slot_free) begin
                        r_out_data  <= w_filt;
                        r_out_valid <= 1'b1;
                        r_out_last  <= 1'b1;
                        r_state     <= ST_FILL;
                    end
                end
                default: r_state <= ST_FILL;
            endcase
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;

endmodule

`default_nettype wire

// File: doc/par_conv_stream.md
PAR_CONV_STREAM -- requirements
Module: par_conv_stream

Interface
REQ-001 Parameter BITS, default 3, log2 of pixel width; PIXELWIDTH = 2**BITS, legal 3..5.
REQ-002 Parameter LANES, default 2, pixels per beat; power of 2, LANES*PIXELWIDTH <= 64.
REQ-003 Parameter LINE_LEN, default 8, pixels per line; multiple of LANES.
REQ-004 Parameters W0/W1/W2, default 1/2/1, unsigned 4-bit kernel taps (left/centre/right).
REQ-005 Parameter SHIFT, default 2, normalisation right shift, 0..6.
REQ-006 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-007 clk  in  1  sole clock, rising edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 in_data  in  LANES*PIXELWIDTH  input beat, lane 0 in LSBs, lane 0 = leftmost pixel.
REQ-010 in_valid  in  1  in_data valid.
REQ-011 in_ready  out  1  block accepts beat this cycle.
REQ-012 out_data  out  LANES*PIXELWIDTH  filtered beat, same lane order.
REQ-013 out_valid  out  1  out_data valid.
REQ-014 out_ready  in  1  downstream accepts.
REQ-015 out_last  out  1  qualifies out_data as final beat of a line.

Function
REQ-016 Transfer occurs when valid and ready are both 1 on a rising edge; out_data/out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-017 Output pixel x: (W0*p[x-1] + W1*p[x] + W2*p[x+1]) >> SHIFT, accumulator width PIXELWIDTH+6, unsigned.
REQ-018 Edge replication: p[-1]=p[0] at line start; p[LINE_LEN]=p[LINE_LEN-1] at line end; no cross-line mixing.
REQ-019 Beat counter 0..LINE_LEN/LANES-1, increments per accepted input beat, wraps to 0 after last beat.
REQ-020 FSM states FILL, RUN, FLUSH; reset state FILL.
REQ-021 FILL: no beat held; accepted beat stored as current; next state RUN, or FLUSH if it is the last beat of line (incl. single-beat lines); no output.
REQ-022 RUN: accepted beat supplies p[x+1] for current beat; output for current beat loaded; accepted beat becomes current; next FLUSH if it was last beat of line, else RUN.
REQ-023 FLUSH: in_ready=0; when output slot free, emit current beat with right-edge replication and out_last=1; next FILL.
REQ-024 Output slot free = out_valid=0 or out_ready=1; in_ready = slot free and state != FLUSH.
REQ-025 Latency: output for beat k appears (out_valid=1) the cycle after beat k+1 is accepted, or after FLUSH edge for the last beat.
REQ-026 Simultaneous output drain and input accept SHALL sustain one beat per cycle within a line; one bubble per line (FLUSH).
REQ-027 out_last=1 only on final beat of a line, else 0.

Reset
REQ-028 rst_n=0 at any time, including mid-line: state FILL, beat counter 0, held beat cleared, out_valid=0, out_last=0, out_data=0, in_ready=0 while rst_n=0.
REQ-029 First beat after reset deassertion is treated as line start.

Configuration
REQ-030 Macro PAR_CONV_SATURATE_EN defined: shifted result > 2**PIXELWIDTH-1 clamps to 2**PIXELWIDTH-1.
REQ-031 Macro PAR_CONV_SATURATE_EN undefined: result truncated to low PIXELWIDTH bits (wrap).

Structure
REQ-032 Shared package par_conv_pkg: FSM state enum, ACC_EXTRA=6 constant, kernel-tap width constant.
REQ-033 One sub-module par_conv_lane: combinational 3-tap MAC, shift and saturate/wrap for one pixel, instantiated LANES times.

Verification (BITS=3, LANES=2, LINE_LEN=4, W=1/2/1, SHIFT=2 unless stated)
REQ-034 Line {10,20},{30,40}, out_ready=1 -> outputs {12,20} then {30,37}, out_last 0 then 1, in_ready 0 for exactly one FLUSH cycle.
REQ-035 W=2/4/2, input all 255: with PAR_CONV_SATURATE_EN -> all 255; without -> all 254.
REQ-036 out_ready=0 for 5 cycles with out_valid=1 -> out_data stable, in_ready=0, no beat lost; stream matches REQ-034 afterwards.
REQ-037 Assert rst_n=0 after first beat of a line, release, send full line {10,20},{30,40} -> output identical to REQ-034.
REQ-038 LINE_LEN=2 (single-beat lines), back-to-back lines {5,9},{100,0} -> {6,8} out_last=1, then {75,25} out_last=1.
